// File: rtl/mxint_dequant_pkg.sv
// Shared constants and types for the MXINT block dequantizer.
package mxint_dequant_pkg;

  // Default configuration of the dequantizer datapath.
  localparam int unsigned DEF_BLOCK_SIZE     = 4;
  localparam int unsigned DEF_OUT_PAR        = 2;
  localparam int unsigned DEF_M_WIDTH        = 8;
  localparam int unsigned DEF_E_WIDTH        = 6;
  localparam int unsigned DEF_OUT_WIDTH      = 16;
  localparam int unsigned DEF_OUT_FRAC_WIDTH = 4;

  // Beat counter needs at least one bit even for single-beat blocks.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NBEATS    = DEF_BLOCK_SIZE / DEF_OUT_PAR;
  localparam int unsigned CNT_WIDTH = cnt_width(NBEATS);

  // Saturation bounds for the default output width.
  localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/mxint_elem_dequant.sv
// One element: signed mantissa scaled by 2^(exp+frac), floored and saturated.
module mxint_elem_dequant #(
  parameter int unsigned M_WIDTH        = 8,
  parameter int unsigned E_WIDTH        = 6,
  parameter int unsigned OUT_WIDTH      = 16,
  parameter int unsigned OUT_FRAC_WIDTH = 4
) (
  input  logic signed [M_WIDTH-1:0]   i_mant,
  input  logic signed [E_WIDTH-1:0]   i_exp,
  output logic signed [OUT_WIDTH-1:0] o_val_c
);

  localparam int unsigned S_WIDTH = E_WIDTH + 2;
  localparam int unsigned WW      = M_WIDTH + OUT_WIDTH;
  localparam logic signed [WW-1:0] SAT_HI = WW'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [WW-1:0] SAT_LO = ~SAT_HI;

  logic signed [S_WIDTH-1:0] w_shift;
  logic        [S_WIDTH-1:0] w_rsh;
  logic signed [WW-1:0]      w_mant_x;
  logic signed [WW-1:0]      w_full;

  // Shift at full precision (any left shift >= OUT_WIDTH saturates), then clamp.
  always_comb begin
    w_shift  = S_WIDTH'(i_exp) + S_WIDTH'(OUT_FRAC_WIDTH);
    w_rsh    = S_WIDTH'(-w_shift);
    w_mant_x = WW'(i_mant);
    w_full   = '0;
    o_val_c  = '0;
    if (!w_shift[S_WIDTH-1]) begin
      if (w_shift >= S_WIDTH'(OUT_WIDTH)) begin
        w_full = i_mant[M_WIDTH-1] ? SAT_LO : SAT_HI;
      end else begin
        w_full = w_mant_x <<< $unsigned(w_shift);
      end
    end else if (w_rsh >= S_WIDTH'(M_WIDTH)) begin
      w_full = i_mant[M_WIDTH-1] ? '1 : '0;
    end else begin
      w_full = w_mant_x >>> w_rsh;
    end
    if (w_full > SAT_HI) begin
      o_val_c = SAT_HI[OUT_WIDTH-1:0];
    end else if (w_full < SAT_LO) begin
      o_val_c = SAT_LO[OUT_WIDTH-1:0];
    end else begin
      o_val_c = w_full[OUT_WIDTH-1:0];
    end
    if (i_mant == '0) begin
      o_val_c = '0;
    end
  end

endmodule

// File: rtl/mxint_block_dequantizer.sv
// Accepts one MXINT block per handshake and streams it out as OUT_PAR-wide fixed-point beats.
module mxint_block_dequantizer
  import mxint_dequant_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE     = DEF_BLOCK_SIZE,
  parameter int unsigned OUT_PAR        = DEF_OUT_PAR,
  parameter int unsigned M_WIDTH        = DEF_M_WIDTH,
  parameter int unsigned E_WIDTH        = DEF_E_WIDTH,
  parameter int unsigned OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter int unsigned OUT_FRAC_WIDTH = DEF_OUT_FRAC_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [BLOCK_SIZE-1:0][M_WIDTH-1:0]   mdata_in,
  input  logic [E_WIDTH-1:0]                   edata_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [OUT_PAR-1:0][OUT_WIDTH-1:0]    data_out,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready,
  output logic                                 data_out_last
);

  localparam int unsigned NB = BLOCK_SIZE / OUT_PAR;
  localparam int unsigned CW = cnt_width(NB);

  state_e                             r_state;
  state_e                             w_state_nxt;
  logic [CW-1:0]                      r_cnt;
  logic [CW-1:0]                      w_cnt_nxt;
  logic                               w_load;
  logic                               w_last;
  logic [BLOCK_SIZE-1:0][M_WIDTH-1:0] r_mant;
  logic [E_WIDTH-1:0]                 r_exp;
  logic [NB-1:0][OUT_PAR-1:0][M_WIDTH-1:0] w_beats;
  logic [OUT_PAR-1:0][M_WIDTH-1:0]    w_sel;

  assign w_last  = (r_cnt == CW'(NB - 1));
  assign w_beats = r_mant;
  assign w_sel   = w_beats[r_cnt];

  // Next-state, counter and handshake decode; ready on the last beat passes through data_out_ready.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_load         = 1'b0;
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    data_out_last  = 1'b0;
    case (r_state)
      IDLE: begin
        data_in_ready = rst;
        if (data_in_valid) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        data_out_valid = 1'b1;
        data_out_last  = w_last;
        data_in_ready  = rst & w_last & data_out_ready;
        if (data_out_ready) begin
          if (!w_last) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end else if (data_in_valid) begin
            w_load    = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Block operand capture on input handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mant <= '0;
      r_exp  <= '0;
    end else if (w_load) begin
      r_mant <= mdata_in;
      r_exp  <= edata_in;
    end
  end

  // One element converter per output lane, fed from the beat selected by the counter.
  for (genvar j = 0; j < OUT_PAR; j++) begin : g_lane
    logic signed [OUT_WIDTH-1:0] w_lane;
    mxint_elem_dequant #(
      .M_WIDTH        (M_WIDTH),
      .E_WIDTH        (E_WIDTH),
      .OUT_WIDTH      (OUT_WIDTH),
      .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH)
    ) u_elem (
      .i_mant  (w_sel[j]),
      .i_exp   (r_exp),
      .o_val_c (w_lane)
    );
    assign data_out[j] = w_lane;
  end

endmodule

// File: tb/tb_mxint_block_dequantizer.sv
// Scoreboard bench for mxint_block_dequantizer with hand-computed beats.
module tb_mxint_block_dequantizer;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][7:0]  mdata_in;
  logic [5:0]       edata_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [1:0][15:0] data_out;
  logic             data_out_valid;
  logic             data_out_ready;
  logic             data_out_last;

  typedef struct packed {
    logic [1:0][15:0] d;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  mxint_block_dequantizer dut (
    .clk            (clk),
    .rst            (rst),
    .mdata_in       (mdata_in),
    .edata_in       (edata_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0][7:0] pm(input logic [7:0] m0, input logic [7:0] m1,
                                         input logic [7:0] m2, input logic [7:0] m3);
    return {m3, m2, m1, m0};
  endfunction

  function automatic logic [1:0][15:0] pk(input logic [15:0] l0, input logic [15:0] l1);
    return {l1, l0};
  endfunction

  // Monitor: pop on each output handshake, verify hold during stalls.
  always @(negedge clk) begin
    if (rst) begin
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(1), 64'(0));
        end else begin
          mon_b = exp_q.pop_front();
          check("beat_data", 64'(data_out), 64'(mon_b.d));
          check("beat_last", 64'(data_out_last), 64'(mon_b.last));
        end
      end else if (data_out_valid && !data_out_ready && exp_q.size() != 0) begin
        check("stall_data", 64'(data_out), 64'(exp_q[0].d));
        check("stall_last", 64'(data_out_last), 64'(exp_q[0].last));
        check("stall_in_ready", 64'(data_in_ready), 64'(0));
      end
    end
  end

  // Present a block, push its beats, wait for acceptance and check first-beat latency.
  task automatic send(input logic [3:0][7:0] m, input logic [5:0] e,
                      input logic [1:0][15:0] b0, input logic [1:0][15:0] b1, input bit b2b);
    int n;
    exp_q.push_back('{d: b0, last: 1'b0});
    exp_q.push_back('{d: b1, last: 1'b1});
    mdata_in      = m;
    edata_in      = e;
    data_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!data_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      check("accept_timeout", 64'(0), 64'(1));
      data_in_valid = 1'b0;
      return;
    end
    if (b2b) begin
      check("b2b_accept_on_last", 64'({data_out_valid, data_out_last, data_out_ready}), 64'(3'b111));
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("first_beat_latency", 64'(data_out_valid), 64'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst            = 1'b0;
    data_in_valid  = 1'b0;
    mdata_in       = '0;
    edata_in       = '0;
    data_out_ready = 1'b1;
    #2;
    check("rst_valid", 64'(data_out_valid), 64'(0));
    check("rst_last", 64'(data_out_last), 64'(0));
    check("rst_in_ready", 64'(data_in_ready), 64'(0));
    check("rst_data", 64'(data_out), 64'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("idle_in_ready", 64'(data_in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Basic block: s = 6
    send(pm(8'(3), 8'(-5), 8'(1), 8'(-1)), 6'(2),
         pk(16'h00C0, 16'hFEC0), pk(16'h0040, 16'hFFC0), 1'b0);
    wait_drain();

    // Negative exponent, floor: s = -2
    send(pm(8'(1), 8'(-1), 8'(5), 8'(-5)), 6'(-6),
         pk(16'h0000, 16'hFFFF), pk(16'h0001, 16'hFFFE), 1'b0);
    wait_drain();

    // Saturation: s = 12
    send(pm(8'(100), 8'(-128), 8'(0), 8'(1)), 6'(8),
         pk(16'h7FFF, 16'h8000), pk(16'h0000, 16'h1000), 1'b0);
    wait_drain();

    // Right shift far beyond mantissa width: s = -28
    send(pm(8'(7), 8'(-7), 8'(0), 8'(127)), 6'(-32),
         pk(16'h0000, 16'hFFFF), pk(16'h0000, 16'h0000), 1'b0);
    wait_drain();

    // Right shift exactly mantissa width: s = -8
    send(pm(8'(127), 8'(-128), 8'(1), 8'(-1)), 6'(-12),
         pk(16'h0000, 16'hFFFF), pk(16'h0000, 16'hFFFF), 1'b0);
    wait_drain();

    // Largest left shift: s = 35
    send(pm(8'(1), 8'(-1), 8'(0), 8'(-128)), 6'(31),
         pk(16'h7FFF, 16'h8000), pk(16'h0000, 16'h8000), 1'b0);
    wait_drain();

    // Saturation edge: s = 15, -1 lands exactly on the minimum
    send(pm(8'(1), 8'(-1), 8'(2), 8'(-2)), 6'(11),
         pk(16'h7FFF, 16'h8000), pk(16'h7FFF, 16'h8000), 1'b0);
    wait_drain();

    // Backpressure: beat 0 stalled for three cycles
    data_out_ready = 1'b0;
    send(pm(8'(9), 8'(-9), 8'(16), 8'(-16)), 6'(-4),
         pk(16'h0009, 16'hFFF7), pk(16'h0010, 16'hFFF0), 1'b0);
    repeat (3) @(posedge clk);
    #1 data_out_ready = 1'b1;
    wait_drain();

    // Back-to-back blocks with valid held
    send(pm(8'(1), 8'(2), 8'(3), 8'(4)), 6'(0),
         pk(16'h0010, 16'h0020), pk(16'h0030, 16'h0040), 1'b0);
    send(pm(8'(-128), 8'(127), 8'(-1), 8'(0)), 6'(-4),
         pk(16'hFF80, 16'h007F), pk(16'hFFFF, 16'h0000), 1'b1);
    send(pm(8'(3), 8'(-3), 8'(-128), 8'(127)), 6'(-5),
         pk(16'h0001, 16'hFFFE), pk(16'hFFC0, 16'h003F), 1'b1);
    wait_drain();

    // Reset after the beat 0 handshake
    exp_q.push_back('{d: pk(16'h0030, 16'h0050), last: 1'b0});
    mdata_in      = pm(8'(3), 8'(5), 8'(7), 8'(9));
    edata_in      = 6'(0);
    data_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!data_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("rstmid_accept", 64'(data_in_ready), 64'(1));
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmid_valid", 64'(data_out_valid), 64'(0));
    check("rstmid_last", 64'(data_out_last), 64'(0));
    check("rstmid_in_ready", 64'(data_in_ready), 64'(0));
    check("rstmid_popped", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(data_in_ready), 64'(1));
    check("post_rst_valid", 64'(data_out_valid), 64'(0));
    repeat (4) @(posedge clk);
    #1 check("post_rst_quiet", 64'(data_out_valid), 64'(0));

    // Normal operation resumes after reset
    send(pm(8'(-2), 8'(2), 8'(0), 8'(-64)), 6'(-3),
         pk(16'hFFFC, 16'h0004), pk(16'h0000, 16'hFF80), 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
